// File: rtl/io_port_ctrl.sv
// Switch/display I/O port: synchronised, debounced switch inputs with sticky change flags
// and interrupt, plus a small register file with registered, one-cycle-latency reads.
module io_port_ctrl #(
  parameter int N_SW     = 5,
  parameter int DISP_W   = 8,
  parameter int DATA_W   = 14,
  parameter int DB_LIMIT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_SW-1:0]   SW_in,
  input  logic [1:0]        Addr,
  input  logic              Wr_en,
  input  logic [DATA_W-1:0] Wr_data,
  input  logic              Rd_en,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Rd_valid,
  output logic [DISP_W-1:0] Display_out,
  output logic              Irq
);

  localparam logic [1:0] ADDR_SW_STATE  = 2'd0;
  localparam logic [1:0] ADDR_SW_CHANGE = 2'd1;
  localparam logic [1:0] ADDR_DISPLAY   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN    = 2'd3;

  // The toggle happens on the edge where the counter would step onto DB_LIMIT.
  localparam logic [7:0] DB_LAST = 8'(DB_LIMIT - 1);

  logic [N_SW-1:0]   sync1_q, sync2_q;
  logic [N_SW-1:0]   db_q, db_d;
  logic [N_SW-1:0]   db_event;
  logic [N_SW-1:0]   chg_q, chg_d;
  logic [N_SW-1:0]   en_q, en_d;
  logic [N_SW-1:0]   w1c_mask;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_mux;
  logic              rd_valid_q, rd_valid_d;
  logic              irq_q, irq_d;
  logic              wr_chg, wr_disp, wr_en_reg;
  logic              unused_wr_bits;

  // Only the low bits of Wr_data land in any register; the rest are intentionally dropped.
  assign unused_wr_bits = ^Wr_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < N_SW; ch++) begin : g_db
    logic [7:0] cnt_q, cnt_d;
    logic       differs;

    assign differs      = sync2_q[ch] != db_q[ch];
    assign db_event[ch] = differs && (cnt_q == DB_LAST);

    always_comb begin
      cnt_d = '0;
      if (differs && !db_event[ch]) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign wr_chg    = Wr_en && (Addr == ADDR_SW_CHANGE);
  assign wr_disp   = Wr_en && (Addr == ADDR_DISPLAY);
  assign wr_en_reg = Wr_en && (Addr == ADDR_IRQ_EN);
  assign w1c_mask  = wr_chg ? Wr_data[N_SW-1:0] : '0;

  // A debounce event is OR-ed in after the clear so it wins a same-edge collision.
  always_comb begin
    db_d   = db_q ^ db_event;
    chg_d  = (chg_q & ~w1c_mask) | db_event;
    en_d   = wr_en_reg ? Wr_data[N_SW-1:0] : en_q;
    disp_d = wr_disp ? Wr_data[DISP_W-1:0] : disp_q;
    irq_d  = |(chg_q & en_q);
  end

  always_comb begin
    rd_mux = '0;
    case (Addr)
      ADDR_SW_STATE:  rd_mux[N_SW-1:0]   = db_q;
      ADDR_SW_CHANGE: rd_mux[N_SW-1:0]   = chg_q;
      ADDR_DISPLAY:   rd_mux[DISP_W-1:0] = disp_q;
      ADDR_IRQ_EN:    rd_mux[N_SW-1:0]   = en_q;
      default:        rd_mux             = '0;
    endcase
  end

  // Read handshake: Rd_valid pulses the cycle after each sampled Rd_en and Rd_data is
  // loaded only then, holding otherwise; there is no ready, so reads never stall. The mux
  // sees register values from before the edge, so a same-edge write is not visible yet.
  always_comb begin
    rd_valid_d = Rd_en;
    rd_data_d  = Rd_en ? rd_mux : rd_data_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      db_q       <= '0;
      chg_q      <= '0;
      en_q       <= '0;
      disp_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      db_q       <= db_d;
      chg_q      <= chg_d;
      en_q       <= en_d;
      disp_q     <= disp_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign Rd_data     = rd_data_q;
  assign Rd_valid    = rd_valid_q;
  assign Display_out = disp_q;
  assign Irq         = irq_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl (N_SW=5, DISP_W=8, DATA_W=14, DB_LIMIT=4): a register
// access table plus hand-written debounce, W1C collision and mid-count reset sequences.
module tb_io_port_ctrl;

  localparam int N_SW     = 5;
  localparam int DISP_W   = 8;
  localparam int DATA_W   = 14;
  localparam int DB_LIMIT = 4;
  localparam int N_VEC    = 15;

  logic              Clock;
  logic              Reset;
  logic [N_SW-1:0]   SW_in;
  logic [1:0]        Addr;
  logic              Wr_en;
  logic [DATA_W-1:0] Wr_data;
  logic              Rd_en;
  logic [DATA_W-1:0] Rd_data;
  logic              Rd_valid;
  logic [DISP_W-1:0] Display_out;
  logic              Irq;

  typedef struct {
    logic              wr_en;
    logic              rd_en;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_valid;
    logic [DISP_W-1:0] exp_disp;
    logic              exp_irq;
  } vec_t;

  vec_t              vecs [N_VEC];
  logic [DATA_W-1:0] exp_q [$];
  int                checks = 0;
  int                errors = 0;

  io_port_ctrl #(
    .N_SW(N_SW), .DISP_W(DISP_W), .DATA_W(DATA_W), .DB_LIMIT(DB_LIMIT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SW_in(SW_in), .Addr(Addr), .Wr_en(Wr_en),
    .Wr_data(Wr_data), .Rd_en(Rd_en), .Rd_data(Rd_data), .Rd_valid(Rd_valid),
    .Display_out(Display_out), .Irq(Irq)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [1:0] a,
                       input logic [DATA_W-1:0] d);
    Wr_en   = wr;
    Rd_en   = rd;
    Addr    = a;
    Wr_data = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 32'(Rd_data), 32'h0);
    check({tag, "_rd_valid"}, 32'(Rd_valid), 32'h0);
    check({tag, "_display"}, 32'(Display_out), 32'h0);
    check({tag, "_irq"}, 32'(Irq), 32'h0);
  endtask

  initial begin
    //            wr    rd    addr   wr_data    exp_rd     vld   disp   irq
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 14'h0000, 14'h0000, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 14'h0000, 14'h0000, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 14'h0000, 14'h0000, 1'b1, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 14'h0000, 14'h0000, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 14'h0000, 14'h0000, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 14'h3FA5, 14'h0000, 1'b1, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 14'h0000, 14'h00A5, 1'b1, 8'hA5, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 14'h0000, 14'h00A5, 1'b0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 14'h3FFF, 14'h00A5, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 14'h0000, 14'h0000, 1'b1, 8'hA5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 14'h3FFF, 14'h0000, 1'b0, 8'hA5, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'd3, 14'h0001, 14'h001F, 1'b1, 8'hA5, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd3, 14'h0000, 14'h0001, 1'b1, 8'hA5, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 2'd2, 14'h005A, 14'h00A5, 1'b1, 8'h5A, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'd1, 14'h3FFF, 14'h0000, 1'b1, 8'h5A, 1'b0};

    Reset = 1'b1;
    SW_in = '0;
    drive(1'b0, 1'b0, 2'd0, '0);
    @(posedge Clock);
    #1;
    check_all_zero("reset");
    @(negedge Clock);
    Reset = 1'b0;
    tick();

    // Register access table with a read scoreboard
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].wr_en, vecs[i].rd_en, vecs[i].addr, vecs[i].wr_data);
      if (vecs[i].rd_en) exp_q.push_back(vecs[i].exp_rd);
      tick();
      check($sformatf("vec%0d_rd_valid", i), 32'(Rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_display", i), 32'(Display_out), 32'(vecs[i].exp_disp));
      check($sformatf("vec%0d_irq", i), 32'(Irq), 32'(vecs[i].exp_irq));
      if (Rd_valid) begin
        check($sformatf("vec%0d_exp_q_nonempty", i), 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0)
          check($sformatf("vec%0d_rd_data", i), 32'(Rd_data), 32'(exp_q.pop_front()));
      end else begin
        check($sformatf("vec%0d_rd_hold", i), 32'(Rd_data), 32'(vecs[i].exp_rd));
      end
    end

    // Debounce bit0 with IRQ_EN=1: state visible at edge 6, Irq at edge 7
    SW_in = 5'b00001;
    drive(1'b0, 1'b1, 2'd0, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("db0_e%0d_state", k), 32'(Rd_data), (k >= 7) ? 32'h1 : 32'h0);
      check($sformatf("db0_e%0d_valid", k), 32'(Rd_valid), 32'h1);
      check($sformatf("db0_e%0d_irq", k), 32'(Irq), (k >= 7) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b1, 2'd1, '0);
    tick();
    check("db0_sw_change", 32'(Rd_data), 32'h0001);
    drive(1'b1, 1'b0, 2'd1, 14'h0001);
    tick();
    check("w1c_irq_same_edge", 32'(Irq), 32'h1);
    drive(1'b0, 1'b0, 2'd0, '0);
    tick();
    check("w1c_irq_next", 32'(Irq), 32'h0);
    drive(1'b0, 1'b1, 2'd1, '0);
    tick();
    check("w1c_sw_change", 32'(Rd_data), 32'h0000);

    // Three-cycle glitch on bit1 must be filtered
    drive(1'b0, 1'b0, 2'd0, '0);
    SW_in = 5'b00011;
    repeat (3) tick();
    SW_in = 5'b00001;
    repeat (8) tick();
    drive(1'b0, 1'b1, 2'd0, '0);
    tick();
    check("glitch_sw_state", 32'(Rd_data), 32'h0001);
    drive(1'b0, 1'b1, 2'd1, '0);
    tick();
    check("glitch_sw_change", 32'(Rd_data), 32'h0000);

    // W1C of bit2 on the edge bit2 debounces: set wins
    drive(1'b0, 1'b0, 2'd0, '0);
    SW_in = 5'b00101;
    repeat (5) tick();
    drive(1'b1, 1'b0, 2'd1, 14'h0004);
    tick();
    drive(1'b0, 1'b1, 2'd1, '0);
    tick();
    check("collide_sw_change", 32'(Rd_data), 32'h0004);
    drive(1'b0, 1'b1, 2'd0, '0);
    tick();
    check("collide_sw_state", 32'(Rd_data), 32'h0005);

    // Reset mid-count on bit1, then full re-debounce of all high switches
    drive(1'b0, 1'b0, 2'd0, '0);
    SW_in = 5'b00111;
    repeat (4) tick();
    Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge Clock);
    Reset = 1'b0;
    drive(1'b0, 1'b1, 2'd0, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("post_rst_e%0d_state", k), 32'(Rd_data), (k >= 7) ? 32'h7 : 32'h0);
    end
    drive(1'b0, 1'b1, 2'd1, '0);
    tick();
    check("post_rst_sw_change", 32'(Rd_data), 32'h0007);
    check("post_rst_display", 32'(Display_out), 32'h0);
    check("post_rst_irq", 32'(Irq), 32'h0);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter N_SW, default 5: number of switch input channels, 1..DATA_W.
REQ-002 Parameter DISP_W, default 8: display output width, 1..DATA_W.
REQ-003 Parameter DATA_W, default 14: processor data bus width.
REQ-004 Parameter DB_LIMIT, default 16: consecutive-cycle count needed to accept a switch change, range 2..255.
REQ-005 Clock  in  1: single clock; all state updates on rising edge.
REQ-006 Reset  in  1: asynchronous, active-high reset.
REQ-007 SW_in  in  N_SW: raw, asynchronous switch inputs.
REQ-008 Addr  in  2: register select. 0=SW_STATE, 1=SW_CHANGE, 2=DISPLAY, 3=IRQ_EN.
REQ-009 Wr_en  in  1: write strobe, sampled on the rising edge.
REQ-010 Wr_data  in  DATA_W: write data.
REQ-011 Rd_en  in  1: read strobe, sampled on the rising edge.
REQ-012 Rd_data  out  DATA_W: registered read data.
REQ-013 Rd_valid  out  1: one-cycle pulse marking Rd_data valid.
REQ-014 Display_out  out  DISP_W: DISPLAY register contents.
REQ-015 Irq  out  1: registered interrupt, the OR over bits of SW_CHANGE AND IRQ_EN.

Function
REQ-016 Each SW_in bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-017 Each channel SHALL have its own debounce counter, 8 bits wide, cleared on any cycle where the synchronised input equals the debounced state.
REQ-018 When the synchronised input differs from the debounced state, the counter SHALL increment each cycle.
REQ-019 On the edge where the counter would reach DB_LIMIT:
  - the debounced bit SHALL toggle;
  - the counter SHALL clear;
  - the channel's SW_CHANGE bit SHALL set.
REQ-020 A raw level held stable SHALL appear in SW_STATE exactly DB_LIMIT+2 rising edges after the first edge that samples it; a glitch shorter than DB_LIMIT synchronised cycles SHALL have no effect.
REQ-021 SW_STATE (addr 0) SHALL be read-only: bits [N_SW-1:0] hold debounced states, upper bits read 0, and writes are ignored.
REQ-022 SW_CHANGE (addr 1) SHALL be sticky and write-1-to-clear per bit; writing 0 leaves a bit unchanged.
REQ-023 If a debounce event and a W1C clear hit the same bit on the same edge, the set SHALL win.
REQ-024 DISPLAY (addr 2) SHALL be read/write on bits [DISP_W-1:0]; upper bits are ignored on write and read as 0; Display_out updates on the edge of the write.
REQ-025 IRQ_EN (addr 3) SHALL be read/write on bits [N_SW-1:0]; upper bits read 0.
REQ-026 Reads SHALL have 1-cycle latency: Rd_en at edge k gives Rd_data and Rd_valid=1 after edge k, and Rd_valid=0 after edge k+1 unless Rd_en is still asserted.
REQ-027 Rd_data SHALL hold its last value when no read is issued.
REQ-028 A read and a write to the same register on the same edge SHALL return the pre-write value.
REQ-029 Irq SHALL be registered and reflect SW_CHANGE and IRQ_EN as they stand after the previous edge, giving 1 cycle of latency from a flag set to Irq.
REQ-030 Back-to-back reads on consecutive edges SHALL each complete with no stall.

Reset
REQ-031 While Reset=1, all of the following SHALL be 0: synchroniser flops, debounce counters, debounced states, SW_CHANGE, IRQ_EN, DISPLAY, Rd_data, Rd_valid, Irq. They take value immediately, independent of Clock.
REQ-032 Reset asserted mid-debounce SHALL discard the partial count; after release, counting restarts from 0 against a debounced state of 0.
REQ-033 After reset release, switches already high SHALL be accepted as changes following normal debounce and SHALL set SW_CHANGE.

Verification (N_SW=5, DISP_W=8, DATA_W=14, DB_LIMIT=4)
REQ-034 Reset, then read addr 0..3 -> Rd_data=0 for each, Rd_valid pulses once per read, Display_out=8'h00, Irq=0.
REQ-035 SW_in=5'b00001 held from edge 1 -> SW_STATE bit0=1 at edge 6 (not 5), SW_CHANGE=14'h0001; a 3-cycle pulse on SW_in[1] leaves SW_STATE and SW_CHANGE bit1 at 0.
REQ-036 Write IRQ_EN=14'h0001, debounce SW_in[0] high -> Irq=1 one cycle after SW_CHANGE[0] sets; write SW_CHANGE=14'h0001 -> Irq=0 the following cycle.
REQ-037 W1C on SW_CHANGE bit2 on the same edge that bit2 debounces -> SW_CHANGE bit2 reads 1.
REQ-038 Write DISPLAY=14'h3FA5 -> Display_out=8'hA5 on that edge, readback 14'h00A5; a same-edge read returns the old value 14'h0000.
REQ-039 Assert Reset asynchronously mid-count (counter=2) -> all outputs 0 before the next edge; SW_in held high after release debounces in a full DB_LIMIT+2 edges.
